// File: rtl/multicycle_datapath.sv
// ============================================================================
// Module   : multicycle_datapath
// Brief    : Multicycle MIPS datapath (PC, IR, MDR, A, B, ALUOut, regfile, ALU)
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multicycle_datapath #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_to_reg,
  input  logic             reg_dest,
  input  logic             i_or_d,
  input  logic             alu_src_a,
  input  logic             ir_write,
  input  logic             mem_write,
  input  logic             pc_write,
  input  logic             branch,
  input  logic             reg_write,
  input  logic [1:0]       alu_src_b,
  input  logic [1:0]       pc_src,
  input  logic [1:0]       alu_op,
  output logic [5:0]       opcode,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;

  localparam logic [2:0] c_ALU_ADD  = 3'd0;
  localparam logic [2:0] c_ALU_SUB  = 3'd1;
  localparam logic [2:0] c_ALU_AND  = 3'd2;
  localparam logic [2:0] c_ALU_OR   = 3'd3;
  localparam logic [2:0] c_ALU_SLT  = 3'd4;
  localparam logic [2:0] c_ALU_ZERO = 3'd5;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_alu_out;
  logic [WIDTH-1:0] r_rf [0:31];

  logic [4:0]       w_rs;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic [4:0]       w_wr_addr;
  logic [WIDTH-1:0] w_wr_data;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic [WIDTH-1:0] w_imm_sx;
  logic [WIDTH-1:0] w_imm_sx_sh;
  logic [WIDTH-1:0] w_src_a;
  logic [WIDTH-1:0] w_src_b;
  logic [2:0]       w_alu_ctl;
  logic [WIDTH-1:0] w_alu_result;
  logic             w_zero;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_pc_en;

  assign w_rs        = r_ir[25:21];
  assign w_rt        = r_ir[20:16];
  assign w_rd        = r_ir[15:11];
  assign w_wr_addr   = reg_dest ? w_rd : w_rt;
  assign w_wr_data   = mem_to_reg ? r_mdr : r_alu_out;
  assign w_rd_a      = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
  assign w_rd_b      = (w_rt == 5'd0) ? '0 : r_rf[w_rt];
  assign w_imm_sx    = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};
  assign w_imm_sx_sh = {w_imm_sx[WIDTH-3:0], 2'b00};

  assign opcode    = r_ir[31:26];
  assign mem_addr  = i_or_d ? r_alu_out : r_pc;
  assign mem_wdata = r_b;
  assign mem_we    = mem_write;

  assign w_src_a = alu_src_a ? r_a : r_pc;

  always_comb begin
    w_src_b = r_b;
    case (alu_src_b)
      2'b00:   w_src_b = r_b;
      2'b01:   w_src_b = WIDTH'(4);
      2'b10:   w_src_b = w_imm_sx;
      default: w_src_b = w_imm_sx_sh;
    endcase
  end

  // Only alu_op=10 consults funct; unrecognised functs force a zero result.
  always_comb begin
    w_alu_ctl = c_ALU_ADD;
    case (alu_op)
      2'b01: w_alu_ctl = c_ALU_SUB;
      2'b10: begin
        case (r_ir[5:0])
          c_FN_ADD: w_alu_ctl = c_ALU_ADD;
          c_FN_SUB: w_alu_ctl = c_ALU_SUB;
          c_FN_AND: w_alu_ctl = c_ALU_AND;
          c_FN_OR:  w_alu_ctl = c_ALU_OR;
          c_FN_SLT: w_alu_ctl = c_ALU_SLT;
          default:  w_alu_ctl = c_ALU_ZERO;
        endcase
      end
      default: w_alu_ctl = c_ALU_ADD;
    endcase
  end

  always_comb begin
    w_alu_result = '0;
    case (w_alu_ctl)
      c_ALU_ADD: w_alu_result = w_src_a + w_src_b;
      c_ALU_SUB: w_alu_result = w_src_a - w_src_b;
      c_ALU_AND: w_alu_result = w_src_a & w_src_b;
      c_ALU_OR:  w_alu_result = w_src_a | w_src_b;
      c_ALU_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
      default:   w_alu_result = '0;
    endcase
  end

  assign w_zero = (w_alu_result == '0);

  always_comb begin
    w_pc_next = r_pc;
    case (pc_src)
      2'b00:   w_pc_next = w_alu_result;
      2'b01:   w_pc_next = r_alu_out;
      2'b10:   w_pc_next = {r_pc[WIDTH-1:28], r_ir[25:0], 2'b00};
      default: w_pc_next = r_pc;
    endcase
  end

  assign w_pc_en = pc_write | (branch & w_zero);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_mdr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
    end else begin
      if (w_pc_en) begin
        r_pc <= w_pc_next;
      end
      if (ir_write) begin
        r_ir <= mem_rdata;
      end
      r_mdr     <= mem_rdata;
      r_a       <= w_rd_a;
      r_b       <= w_rd_b;
      r_alu_out <= w_alu_result;
    end
  end

  // Register 0 is never written, so it always holds its reset value of zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
    end else if (reg_write && (w_wr_addr != 5'd0)) begin
      r_rf[w_wr_addr] <= w_wr_data;
    end
  end

endmodule

`default_nettype wire
